conv_host_sequencer: RTL and testbench
======================================

Name: conv_host_sequencer

Overview:
- Host-side initiator for the convolution coprocessor.
- Accepts a job (size plus a stream of 8-bit Y samples) and writes the samples into memory Y through its write port.
- Starts the coprocessor and waits for its done pulse, with a watchdog.
- Reads the (sizeY+SIZE_H-1) 16-bit results back from memory Z's read port and streams them out under valid/ready.

Parameters:
- DATA_WIDTH_MEMY, 8, Y sample width
- ADDR_WIDTH_MEMY, 5, memory Y address width
- DATA_WIDTH_MEMZ, 16, Z result width
- ADDR_WIDTH_MEMZ, 6, memory Z address width
- SIZE_H, 5, kernel length; number of Z words = size+SIZE_H-1
- TIMEOUT_CYCLES, 1023, maximum cycles in WAIT before abort

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- job_start  in  1  one-cycle request; honoured only in IDLE
- job_size  in  5  number of Y samples, sampled with job_start
- in_data  in  8  Y sample
- in_valid  in  1  sample valid
- in_ready  out  1  sequencer accepts sample
- memY_we  out  1  memory Y write enable
- memY_waddr  out  5  memory Y write address
- memY_wdata  out  8  memory Y write data
- cop_sizeY  out  5  size presented to coprocessor sizeY
- cop_start  out  1  coprocessor start pulse
- cop_busy  in  1  coprocessor busy (status only)
- cop_done  in  1  coprocessor done
- memZ_raddr  out  6  memory Z read address
- memZ_rdata  in  16  memory Z read data, valid 1 cycle after address
- out_data  out  16  result word
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_last  out  1  marks final result word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of job (normal or aborted)
- timeout_err  out  1  sticky; cleared by the next accepted job_start

Behaviour:
- Reset (rstn=0 at a rising edge): state IDLE. All outputs 0 (timeout_err included), counters 0. Reset mid-job aborts with no done pulse.
- IDLE: in_ready=0. On job_start, latch size into cop_sizeY.
  - size==0: done pulse next cycle, remain IDLE, coprocessor not started.
  - Otherwise go to LOAD. timeout_err cleared.
  - job_start outside IDLE is ignored.
- LOAD: in_ready=1. Each in_valid&in_ready cycle drives memY_we=1, memY_waddr=count, memY_wdata=in_data in the same cycle (combinational from the handshake), then count++. After the size-th write, go to START.
- START: cop_start=1 for exactly one cycle; cop_sizeY held stable from LOAD until the job ends. Go to WAIT.
- WAIT: watchdog counts cycles.
  - cop_done=1: go to RD_ADDR with rd_idx=0.
  - Watchdog reaches TIMEOUT_CYCLES with no cop_done: set timeout_err, pulse done, go to IDLE.
  - cop_done on the same cycle as expiry: done wins, no error.
- RD_ADDR: drive memZ_raddr=rd_idx. Go to RD_WAIT.
- RD_WAIT: one-cycle RAM latency. Go to OUT.
- OUT:
  - out_data is registered from memZ_rdata on entry and held stable while out_valid=1 and out_ready=0.
  - out_last=1 when rd_idx==size+SIZE_H-2.
  - On out_ready: if last, pulse done and go to IDLE; else rd_idx++ and go to RD_ADDR.
  - Throughput is 1 word per 3 cycles; this rate is fixed for this block.
- Widths:
  - Z count = size+SIZE_H-1, computed in 6 bits; max 31+4=35, which is ≤64.
  - memZ_raddr zero-extends rd_idx.
- busy=1 in LOAD, START, WAIT, RD_ADDR, RD_WAIT and OUT.
- done is never asserted together with out_valid on a non-last word.

Decomposition:
- Package conv_host_pkg holds:
  - state enum (IDLE, LOAD, START, WAIT, RD_ADDR, RD_WAIT, OUT)
  - width constants matching the coprocessor (8/5/16/6)
  - SIZE_H default
- One natural sub-module: conv_host_watchdog (load/clear, enable, expire flag). Everything else stays in one FSM module.

Test Plan:
- Nominal run: bench uses a behavioural coprocessor that sets Z[i]=16'h0100+i and pulses done 20 cycles after start. Stimulus: job_size=5, Y=1..5. Required response:
  - memY writes at addresses 0..4 with data 1..5.
  - One cop_start pulse with cop_sizeY=5.
  - 9 output words 0x0100..0x0108, out_last only on 0x0108, then one done pulse.
- Backpressure: out_ready toggles 1-in-3 → no word lost or duplicated; out_data stable while stalled; same 9-word sequence.
- Timeout: model never pulses done, TIMEOUT_CYCLES=50 → timeout_err=1 and a done pulse 50 cycles after WAIT entry; memZ never read. A following job clears timeout_err.
- job_size=0 → done pulse 1 cycle after job_start; cop_start never asserted; no memY writes.
- Reset mid-LOAD: rstn=0 after 2 of 5 samples → next cycle all outputs 0 and state IDLE. A new size-3 job then completes correctly with 7 words.
- job_start pulsed during WAIT and OUT → ignored; the current job finishes with its original size; no extra cop_start.

Source files
------------

// File: rtl/conv_host_pkg.sv
// Shared definitions for the convolution coprocessor host sequencer.
// Holds the sequencer state encoding, the memory width constants that
// match the coprocessor, and the default kernel length / watchdog limit.
package conv_host_pkg;

  localparam int CONV_DW_Y     = 8;     // memory Y data width
  localparam int CONV_AW_Y     = 5;     // memory Y address width
  localparam int CONV_DW_Z     = 16;    // memory Z data width
  localparam int CONV_AW_Z     = 6;     // memory Z address width
  localparam int CONV_SIZE_H   = 5;     // kernel length
  localparam int CONV_TIMEOUT  = 1023;  // watchdog limit in WAIT cycles

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_OUT     = 3'd6
  } state_e;

endpackage

// File: rtl/conv_host_watchdog.sv
// Cycle watchdog for the coprocessor wait phase.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   clear     : force the count back to zero
//   en        : count one cycle
//   expired   : high during the TIMEOUT_CYCLES-th enabled cycle
module conv_host_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The count equals the number of earlier enabled cycles, so the flag
  // rises on the cycle that completes the allowed budget.
  assign expired = en && !clear && (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_host_sequencer.sv
// Host-side initiator for the convolution coprocessor.
// Loads a job's Y samples into memory Y, starts the coprocessor, waits for
// its done pulse under a watchdog, then streams size+SIZE_H-1 results from
// memory Z out under valid/ready (one word per three cycles).
// Ports:
//   job_start/job_size          : job request, honoured only when idle
//   in_data/in_valid/in_ready   : Y sample stream
//   memY_we/waddr/wdata         : memory Y write port
//   cop_sizeY/cop_start/busy/done : coprocessor control
//   memZ_raddr/memZ_rdata       : memory Z read port (1-cycle latency)
//   out_data/valid/ready/last   : result stream
//   busy/done/timeout_err       : job status
module conv_host_sequencer
  import conv_host_pkg::*;
#(
  parameter int DATA_WIDTH_MEMY = CONV_DW_Y,
  parameter int ADDR_WIDTH_MEMY = CONV_AW_Y,
  parameter int DATA_WIDTH_MEMZ = CONV_DW_Z,
  parameter int ADDR_WIDTH_MEMZ = CONV_AW_Z,
  parameter int SIZE_H          = CONV_SIZE_H,
  parameter int TIMEOUT_CYCLES  = CONV_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       job_start,
  input  logic [ADDR_WIDTH_MEMY-1:0] job_size,
  input  logic [DATA_WIDTH_MEMY-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       memY_we,
  output logic [ADDR_WIDTH_MEMY-1:0] memY_waddr,
  output logic [DATA_WIDTH_MEMY-1:0] memY_wdata,
  output logic [ADDR_WIDTH_MEMY-1:0] cop_sizeY,
  output logic                       cop_start,
  input  logic                       cop_busy,
  input  logic                       cop_done,
  output logic [ADDR_WIDTH_MEMZ-1:0] memZ_raddr,
  input  logic [DATA_WIDTH_MEMZ-1:0] memZ_rdata,
  output logic [DATA_WIDTH_MEMZ-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH_MEMY-1:0] count_q, count_d;
  logic [ADDR_WIDTH_MEMY-1:0] size_q, size_d;
  logic [ADDR_WIDTH_MEMZ-1:0] rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH_MEMZ-1:0] out_data_q, out_data_d;
  logic                       done_q, done_d;
  logic                       terr_q, terr_d;
  logic                       wd_expired;
  logic [ADDR_WIDTH_MEMZ-1:0] z_last;
  logic                       unused_cop_busy;

  // Coprocessor busy is informational only; the done pulse drives the FSM.
  assign unused_cop_busy = cop_busy;

  // Index of the final Z word: size + SIZE_H - 2, widened before the add.
  assign z_last = ADDR_WIDTH_MEMZ'(size_q) + ADDR_WIDTH_MEMZ'(SIZE_H - 2);

  conv_host_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (state_q != ST_WAIT),
    .en      (state_q == ST_WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    size_d     = size_q;
    rd_idx_d   = rd_idx_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    terr_d     = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          size_d  = job_size;
          terr_d  = 1'b0;
          count_d = '0;
          if (job_size == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (count_q == size_q - 1'b1) begin
            count_d = '0;
            state_d = ST_START;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (cop_done) begin
          rd_idx_d = '0;
          state_d  = ST_RD_ADDR;
        end else if (wd_expired) begin
          terr_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        out_data_d = memZ_rdata;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (rd_idx_q == z_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = ST_RD_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      size_q     <= '0;
      rd_idx_q   <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      size_q     <= size_d;
      rd_idx_q   <= rd_idx_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
    end
  end

  assign in_ready    = (state_q == ST_LOAD);
  assign memY_we     = (state_q == ST_LOAD) && in_valid;
  assign memY_waddr  = count_q;
  assign memY_wdata  = in_data;
  assign cop_sizeY   = size_q;
  assign cop_start   = (state_q == ST_START);
  assign memZ_raddr  = rd_idx_q;
  assign out_data    = out_data_q;
  assign out_valid   = (state_q == ST_OUT);
  assign out_last    = (state_q == ST_OUT) && (rd_idx_q == z_last);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_conv_host_sequencer.sv
module tb_conv_host_sequencer;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        job_start = 1'b0;
  logic [4:0]  job_size = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        memY_we;
  logic [4:0]  memY_waddr;
  logic [7:0]  memY_wdata;
  logic [4:0]  cop_sizeY;
  logic        cop_start;
  logic        cop_busy = 1'b0;
  logic        cop_done = 1'b0;
  logic [5:0]  memZ_raddr;
  logic [15:0] memZ_rdata = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        timeout_err;

  conv_host_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .job_start(job_start), .job_size(job_size),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .memY_we(memY_we), .memY_waddr(memY_waddr), .memY_wdata(memY_wdata),
    .cop_sizeY(cop_sizeY), .cop_start(cop_start), .cop_busy(cop_busy),
    .cop_done(cop_done), .memZ_raddr(memZ_raddr), .memZ_rdata(memZ_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Coprocessor and memory models: Z[i] = 0x0100+i, done 20 cycles after start.
  bit       cop_respond = 1'b1;
  int       cop_tmr = 0;
  logic [7:0] ymem [32];

  always @(posedge clk) begin
    memZ_rdata <= 16'h0100 + {10'd0, memZ_raddr};
    if (memY_we) ymem[memY_waddr] <= memY_wdata;
    if (!rstn) begin
      cop_tmr  <= 0;
      cop_done <= 1'b0;
      cop_busy <= 1'b0;
    end else begin
      cop_done <= cop_respond && (cop_tmr == 1);
      if (cop_start) cop_tmr <= 20;
      else if (cop_tmr != 0) cop_tmr <= cop_tmr - 1;
      cop_busy <= cop_start || (cop_tmr > 1);
    end
  end

  // Downstream ready pattern.
  bit rmode = 1'b0;
  initial begin
    int rc = 0;
    forever begin
      @(posedge clk); #1;
      rc++;
      out_ready = rmode ? (rc % 3 == 0) : 1'b1;
    end
  end

  // Behavioural job model (phases: 0 idle, 1 load, 2 coprocessor, 3 readout).
  int   cyc = 0;
  bit   live = 1'b0;
  int   ph = 0, m_size = 0, wr = 0, start_cyc = 0, vld_cyc = 0, rd = 0;
  logic done_e = 1'b0, terr_e = 1'b0;
  int   n_hs = 0, n_lastw = 0, n_wr = 0, n_st = 0;
  int   last_start_cyc = 0, last_done_cyc = 0;
  logic [15:0] last_word = '0;

  always @(negedge clk) begin
    logic e_ov, e_we, e_st;
    int zc;
    logic done_n;
    cyc++;
    if (out_valid && out_ready) begin n_hs++; last_word = out_data; if (out_last) n_lastw++; end
    if (memY_we) n_wr++;
    if (cop_start) begin n_st++; last_start_cyc = cyc; end
    if (done) last_done_cyc = cyc;
    if (live) begin
      zc   = m_size + 4;
      e_we = (ph == 1) && in_valid;
      e_st = (ph == 2) && (cyc == start_cyc);
      e_ov = (ph == 3) && (cyc >= vld_cyc);
      chk("busy", busy, ph != 0);
      chk("in_ready", in_ready, ph == 1);
      chk("memY_we", memY_we, e_we);
      chk("cop_start", cop_start, e_st);
      chk("out_valid", out_valid, e_ov);
      chk("out_last", out_last, e_ov && (rd == zc - 1));
      chk("done", done, done_e);
      chk("timeout_err", timeout_err, terr_e);
      if (e_we) begin
        chk("memY_waddr", memY_waddr, wr);
        chk("memY_wdata", memY_wdata, in_data);
      end
      if (ph != 0) chk("cop_sizeY", cop_sizeY, m_size);
      if (e_ov) chk("out_data", out_data, 16'h0100 + rd);
      done_n = 1'b0;
      case (ph)
        0: if (job_start) begin
             m_size = job_size;
             terr_e = 1'b0;
             if (job_size == 0) done_n = 1'b1;
             else begin ph = 1; wr = 0; end
           end
        1: if (in_valid) begin
             wr++;
             if (wr == m_size) begin ph = 2; start_cyc = cyc + 1; end
           end
        2: if (cyc > start_cyc && cop_done) begin
             ph = 3; rd = 0; vld_cyc = cyc + 3;
           end else if (cyc == start_cyc + TO) begin
             ph = 0; done_n = 1'b1; terr_e = 1'b1;
           end
        3: if (cyc >= vld_cyc && out_ready) begin
             if (rd == zc - 1) begin ph = 0; done_n = 1'b1; end
             else begin rd++; vld_cyc = cyc + 3; end
           end
        default: ph = 0;
      endcase
      done_e = done_n;
    end
    if (!rstn) begin
      live = 1'b1; ph = 0; done_e = 1'b0; terr_e = 1'b0;
    end
  end

  // Stimulus helpers.
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_job(input int sz);
    job_start = 1'b1;
    job_size  = 5'(sz);
    tick(1);
    job_start = 1'b0;
  endtask

  task automatic load(input int n, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i == 2) begin in_valid = 1'b0; tick(1); end
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!done && k < bound);
    chk(name, done, 1'b1);
    tick(1);
  endtask

  task automatic wait_valid(input int bound);
    int k = 0;
    while (!out_valid && k < bound) begin tick(1); k++; end
    chk("wait_out_valid", out_valid, 1'b1);
  endtask

  int hs0, st0, wr0;

  initial begin
    tick(3);
    rstn = 1'b1;
    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_cop_sizeY", cop_sizeY, 5'd0);

    // Nominal job: size 5, Y = 1..5
    hs0 = n_hs; st0 = n_st;
    start_job(5);
    load(5, 1, 1'b0);
    wait_done(300, "nominal_done");
    for (int i = 0; i < 5; i++) chk("ymem", ymem[i], 8'(i + 1));
    chk("nominal_words", n_hs - hs0, 9);
    chk("nominal_last_word", last_word, 16'h0108);
    chk("nominal_lasts", n_lastw, 1);
    chk("nominal_starts", n_st - st0, 1);

    // Backpressure: ready 1-in-3, sample gap during load
    rmode = 1'b1; hs0 = n_hs;
    start_job(5);
    load(5, 8'h10, 1'b1);
    wait_done(400, "bp_done");
    chk("bp_words", n_hs - hs0, 9);
    chk("bp_last_word", last_word, 16'h0108);
    chk("ymem_bp", ymem[4], 8'h14);
    rmode = 1'b0;

    // Timeout: coprocessor never answers
    cop_respond = 1'b0; hs0 = n_hs;
    start_job(3);
    load(3, 8'h20, 1'b0);
    wait_done(200, "to_done");
    chk("to_err", timeout_err, 1'b1);
    chk("to_latency", last_done_cyc - last_start_cyc, TO + 1);
    chk("to_no_words", n_hs - hs0, 0);
    cop_respond = 1'b1;
    start_job(2);
    chk("to_err_cleared", timeout_err, 1'b0);
    load(2, 8'h30, 1'b0);
    wait_done(300, "after_to_done");
    chk("after_to_last_word", last_word, 16'h0105);

    // Size zero job
    st0 = n_st; wr0 = n_wr;
    start_job(0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    tick(1);
    chk("zero_done_clear", done, 1'b0);
    chk("zero_no_start", n_st - st0, 0);
    chk("zero_no_writes", n_wr - wr0, 0);

    // Reset mid-LOAD
    start_job(5);
    load(2, 8'h40, 1'b0);
    rstn = 1'b0;
    tick(1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_cop_sizeY", cop_sizeY, 5'd0);
    chk("midrst_out_data", out_data, 16'h0);
    chk("midrst_done", done, 1'b0);
    rstn = 1'b1;
    hs0 = n_hs;
    start_job(3);
    load(3, 7, 1'b0);
    wait_done(300, "midrst_job_done");
    chk("midrst_words", n_hs - hs0, 7);
    chk("midrst_last_word", last_word, 16'h0106);
    chk("midrst_ymem", ymem[2], 8'd9);

    // job_start during WAIT and OUT is ignored
    hs0 = n_hs; st0 = n_st;
    start_job(4);
    load(4, 8'h50, 1'b0);
    tick(4);
    start_job(9);
    wait_valid(100);
    start_job(1);
    wait_done(300, "ignore_done");
    chk("ignore_words", n_hs - hs0, 8);
    chk("ignore_last_word", last_word, 16'h0107);
    chk("ignore_starts", n_st - st0, 1);
    chk("ignore_sizeY", cop_sizeY, 5'd4);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
